// File: rtl/fifo_rr_drain_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rr_drain_pkg
// Shared sizing constants for the round-robin FIFO drain block.
//   BUF_DEPTH : entries in the output skid buffer (head + tail)
//   CNT_W     : width of the buffer occupancy counter (holds 0..BUF_DEPTH)
//   OCC_W     : width used to evaluate buffered + in-flight - popped, wide
//               enough that the intermediate sum never wraps
// ---------------------------------------------------------------------------
package fifo_rr_drain_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;
  localparam int OCC_W     = 3;

  // Entries that will be held after this edge if nothing new is issued.
  // pop implies count >= 1, so the subtraction cannot underflow.
  function automatic logic [OCC_W-1:0] occupancyAfter(
    input logic [CNT_W-1:0] count,
    input logic             inflight,
    input logic             pop
  );
    occupancyAfter = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority selector. The search starts at the source
// just after the previously granted one and wraps around, so the most recent
// winner always has lowest priority.
// Ports:
//   req_i    [NUM_SRC] request vector, bit i belongs to source i
//   last_i   [SRC_W]   index of the previous grant
//   gnt_o    [NUM_SRC] one-hot grant (all zero when nothing requests)
//   gntIdx_o [SRC_W]   binary index of the grant
//   any_o              at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_W-1:0]   last_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [SRC_W-1:0]   gntIdx_o,
  output logic               any_o
);

  // Scan last+1, last+2, ... modulo NUM_SRC and take the first requester.
  // Offset NUM_SRC lands back on last itself, so a lone requester that was
  // also the previous winner is still granted.
  always_comb begin
    logic             found;
    int               idx;
    logic [SRC_W-1:0] idxNarrow;
    gnt_o     = '0;
    gntIdx_o  = '0;
    found     = 1'b0;
    idx       = 0;
    idxNarrow = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx       = (int'(last_i) + k) % NUM_SRC;
      idxNarrow = SRC_W'(idx);
      if (!found && req_i[idxNarrow]) begin
        found            = 1'b1;
        gnt_o[idxNarrow] = 1'b1;
        gntIdx_o         = idxNarrow;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fifo_rr_drain.sv
// ---------------------------------------------------------------------------
// fifo_rr_drain
// Round-robin read scheduler sharing one downstream consumer between NUM_SRC
// synchronous-read FIFOs. At most one FIFO is read per cycle; its data comes
// back one cycle later and is captured into a 2-entry output buffer that is
// presented as a ready/valid stream tagged with the source index.
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   fifo_empty  [NUM_SRC]        per-source empty flag
//   fifo_rd_en  [NUM_SRC]        per-source read strobe, one-hot or zero
//   fifo_dout   [NUM_SRC*WIDTH]  per-source read data, source i at [i*WIDTH +: WIDTH]
//   out_valid                    head entry available
//   out_ready                    consumer accepts head entry
//   out_data    [WIDTH]          head entry data
//   out_src     [SRC_W]          head entry source index
// ---------------------------------------------------------------------------
module fifo_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       fifo_empty,
  output logic [NUM_SRC-1:0]       fifo_rd_en,
  input  logic [NUM_SRC*WIDTH-1:0] fifo_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [SRC_W-1:0] inflightSrc_q, inflightSrc_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic [WIDTH-1:0] headData_q, headData_d;
  logic [SRC_W-1:0] headSrc_q, headSrc_d;
  logic [WIDTH-1:0] tailData_q, tailData_d;
  logic [SRC_W-1:0] tailSrc_q, tailSrc_d;

  logic [NUM_SRC-1:0] gnt;
  logic [SRC_W-1:0]   gntIdx;
  logic               anyReq;
  logic               pop;
  logic               issue;
  logic [WIDTH-1:0]   doutArr [NUM_SRC];
  logic [WIDTH-1:0]   capData;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) uRrPick (
    .req_i    (~fifo_empty),
    .last_i   (last_q),
    .gnt_o    (gnt),
    .gntIdx_o (gntIdx),
    .any_o    (anyReq)
  );

  // Split the flat read-data bus into one word per source.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      doutArr[i] = fifo_dout[i*WIDTH +: WIDTH];
    end
  end

  assign capData   = doutArr[inflightSrc_q];
  assign out_valid = (count_q != '0);
  assign out_data  = headData_q;
  assign out_src   = headSrc_q;
  assign pop       = out_valid && out_ready;

  // Credit check: only read when the entry it returns is guaranteed a slot,
  // counting what is buffered and in flight after this cycle's pop.
  assign issue = (occupancyAfter(count_q, inflight_q, pop) <= OCC_W'(1)) && anyReq;

  // The strobe is forced low while reset is held so the shared FIFOs are not
  // popped during the same event that clears them.
  assign fifo_rd_en = (issue && !rst) ? gnt : '0;

  // Read tracking: remember which source was read so its data is tagged
  // correctly when it arrives next cycle, and advance the RR pointer.
  always_comb begin
    inflight_d    = issue;
    inflightSrc_d = inflightSrc_q;
    last_d        = last_q;
    if (issue) begin
      inflightSrc_d = gntIdx;
      last_d        = gntIdx;
    end
  end

  // Output buffer: head is what the consumer sees, tail holds the second
  // entry. Capture and pop in the same cycle keep the count and preserve
  // order because the new word always goes behind the surviving entry.
  always_comb begin
    count_d    = count_q;
    headData_d = headData_q;
    headSrc_d  = headSrc_q;
    tailData_d = tailData_q;
    tailSrc_d  = tailSrc_q;
    case (count_q)
      CNT_W'(0): begin
        if (inflight_q) begin
          headData_d = capData;
          headSrc_d  = inflightSrc_q;
          count_d    = CNT_W'(1);
        end
      end
      CNT_W'(1): begin
        if (pop && inflight_q) begin
          headData_d = capData;
          headSrc_d  = inflightSrc_q;
        end else if (pop) begin
          count_d = CNT_W'(0);
        end else if (inflight_q) begin
          tailData_d = capData;
          tailSrc_d  = inflightSrc_q;
          count_d    = CNT_W'(2);
        end
      end
      default: begin
        if (pop) begin
          headData_d = tailData_q;
          headSrc_d  = tailSrc_q;
          if (inflight_q) begin
            tailData_d = capData;
            tailSrc_d  = inflightSrc_q;
          end else begin
            count_d = CNT_W'(1);
          end
        end
      end
    endcase
  end

  // State registers. last resets to the highest index so source 0 wins the
  // first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflightSrc_q <= '0;
      last_q        <= SRC_W'(NUM_SRC - 1);
      headData_q    <= '0;
      headSrc_q     <= '0;
      tailData_q    <= '0;
      tailSrc_q     <= '0;
    end else begin
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflightSrc_q <= inflightSrc_d;
      last_q        <= last_d;
      headData_q    <= headData_d;
      headSrc_q     <= headSrc_d;
      tailData_q    <= tailData_d;
      tailSrc_q     <= tailSrc_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_drain
// Directed and random bench for fifo_rr_drain. Source FIFOs are modelled as
// queues; every read strobe pushes the expected word onto a scoreboard that
// is popped and compared whenever the consumer accepts an entry.
// ---------------------------------------------------------------------------
module tb_fifo_rr_drain;

  localparam int WIDTH   = 8;
  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SRC_W-1:0] src;
  } sbEntry_t;

  logic                     clk;
  logic                     rst;
  logic [NUM_SRC-1:0]       fifo_empty;
  logic [NUM_SRC-1:0]       fifo_rd_en;
  logic [NUM_SRC*WIDTH-1:0] fifo_dout;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SRC_W-1:0]         out_src;

  logic [WIDTH-1:0] srcQ [NUM_SRC][$];
  sbEntry_t         sbQ [$];
  logic             prevIssued;

  logic [NUM_SRC-1:0] rdEnS;
  logic               validS;
  logic               readyS;
  logic [WIDTH-1:0]   dataS;
  logic [SRC_W-1:0]   srcS;

  int checks;
  int errors;

  fifo_rr_drain #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refreshEmpty();
    for (int i = 0; i < NUM_SRC; i++) begin
      fifo_empty[i] = (srcQ[i].size() == 0);
    end
  endtask

  // One clock cycle. Entered at rising edge + 4; samples outputs at the
  // falling edge, checks them against the scoreboard, then models the
  // source FIFOs returning data one cycle after the strobe.
  task automatic applyStimulus();
    int       expBuffered;
    sbEntry_t e;
    refreshEmpty();
    #1;
    rdEnS  = fifo_rd_en;
    validS = out_valid;
    readyS = out_ready;
    dataS  = out_data;
    srcS   = out_src;
    expBuffered = sbQ.size() - (prevIssued ? 1 : 0);
    checkOutput("out_valid", 32'(validS), 32'(expBuffered != 0));
    checkOutput("outstanding_le_2", 32'(sbQ.size() <= 2), 32'(1));
    if (validS && readyS) begin
      if (sbQ.size() == 0) begin
        checkOutput("pop_without_entry", 32'(sbQ.size()), 32'(1));
      end else begin
        e = sbQ.pop_front();
        checkOutput("out_data", 32'(dataS), 32'(e.data));
        checkOutput("out_src", 32'(srcS), 32'(e.src));
      end
    end
    checkOutput("rd_en_onehot0", 32'($onehot0(rdEnS)), 32'(1));
    checkOutput("rd_en_on_empty", 32'(rdEnS & fifo_empty), 32'(0));
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rdEnS[i] && srcQ[i].size() > 0) begin
        e.data = srcQ[i][0];
        e.src  = SRC_W'(i);
        sbQ.push_back(e);
      end
    end
    prevIssued = |rdEnS;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rdEnS[i] && srcQ[i].size() > 0) begin
        fifo_dout[i*WIDTH +: WIDTH] = srcQ[i].pop_front();
      end
    end
    refreshEmpty();
    #3;
  endtask

  // Asserts reset, checks the outputs clear immediately, and clears the
  // modelled FIFOs which share the same reset.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'(0));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_data", 32'(out_data), 32'(0));
    checkOutput("rst_out_src", 32'(out_src), 32'(0));
    for (int i = 0; i < NUM_SRC; i++) srcQ[i].delete();
    sbQ.delete();
    prevIssued = 1'b0;
    fifo_dout  = '0;
    refreshEmpty();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int issued;
    int remaining;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    out_ready  = 1'b0;
    fifo_dout  = '0;
    fifo_empty = '1;
    prevIssued = 1'b0;
    @(posedge clk);
    #4;

    // 1. Reset, idle, then reset in the middle of traffic.
    $display("[TB] reset and idle");
    doReset();
    out_ready = 1'b1;
    for (int s = 0; s < 10; s++) begin
      applyStimulus();
      checkOutput("idle_rd_en", 32'(rdEnS), 32'(0));
    end
    out_ready = 1'b0;
    srcQ[0].push_back(8'h11);
    srcQ[1].push_back(8'h22);
    for (int s = 0; s < 3; s++) applyStimulus();
    checkOutput("pre_reset_valid", 32'(validS), 32'(1));
    doReset();

    // 2. Single source latency: read in t, data visible in t+2.
    $display("[TB] single source latency");
    out_ready = 1'b1;
    srcQ[2].push_back(8'hA5);
    applyStimulus();
    checkOutput("lat_rd_en", 32'(rdEnS), 32'(4'b0100));
    applyStimulus();
    checkOutput("lat_t1_valid", 32'(validS), 32'(0));
    applyStimulus();
    checkOutput("lat_t2_valid", 32'(validS), 32'(1));
    checkOutput("lat_t2_data", 32'(dataS), 32'(8'hA5));
    checkOutput("lat_t2_src", 32'(srcS), 32'(2));

    // 3. All sources busy: grants rotate and output streams every cycle.
    $display("[TB] round-robin rotation");
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < 2; k++) srcQ[i].push_back(8'(16 * (i + 1) + k));
    end
    for (int s = 0; s < 10; s++) begin
      applyStimulus();
      if (s < 8) checkOutput("rot_grant", 32'(rdEnS), 32'(1 << (s % 4)));
      if (s >= 2) begin
        checkOutput("rot_valid", 32'(validS), 32'(1));
        checkOutput("rot_src", 32'(srcS), 32'((s - 2) % 4));
      end
    end

    // 4. Empty sources skipped without bubbles.
    $display("[TB] skip empty sources");
    doReset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      srcQ[0].push_back(8'(8'h40 + k));
      srcQ[2].push_back(8'(8'h60 + k));
    end
    for (int s = 0; s < 6; s++) begin
      applyStimulus();
      checkOutput("skip_grant", 32'(rdEnS), (s % 2 == 0) ? 32'(4'b0001) : 32'(4'b0100));
    end

    // 5. Backpressure: two outstanding then stall, then drain in order.
    $display("[TB] backpressure");
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < 3; k++) srcQ[i].push_back(8'(8'h80 + 16 * i + k));
    end
    issued = 0;
    for (int s = 0; s < 6; s++) begin
      applyStimulus();
      issued += $countones(rdEnS);
    end
    checkOutput("bp_issued", 32'(issued), 32'(2));
    checkOutput("bp_stalled_rd_en", 32'(rdEnS), 32'(0));
    checkOutput("bp_valid", 32'(validS), 32'(1));
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("bp_first_src", 32'(srcS), 32'(0));
    checkOutput("bp_first_data", 32'(dataS), 32'(8'h80));
    applyStimulus();
    checkOutput("bp_second_src", 32'(srcS), 32'(1));
    checkOutput("bp_second_data", 32'(dataS), 32'(8'h90));
    for (int s = 0; s < 40; s++) applyStimulus();
    remaining = 0;
    for (int i = 0; i < NUM_SRC; i++) remaining += srcQ[i].size();
    checkOutput("bp_drained_sb", 32'(sbQ.size()), 32'(0));
    checkOutput("bp_drained_src", 32'(remaining), 32'(0));

    // 6. Random traffic and backpressure against the scoreboard.
    $display("[TB] random stress");
    doReset();
    for (int s = 0; s < 10000; s++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (srcQ[i].size() < 4 && $urandom_range(0, 2) == 0) begin
          srcQ[i].push_back(8'($urandom_range(0, 255)));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    out_ready = 1'b1;
    for (int s = 0; s < 60; s++) applyStimulus();
    remaining = 0;
    for (int i = 0; i < NUM_SRC; i++) remaining += srcQ[i].size();
    checkOutput("rand_drained_sb", 32'(sbQ.size()), 32'(0));
    checkOutput("rand_drained_src", 32'(remaining), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
